branch_resolve_unit: RTL and testbench

Parametrised next-generation branch execution unit. Accepts resolved-operand jal/jalr/conditional-branch ops from issue with a valid/ready handshake, computes the actual outcome, and compares it against the front-end prediction. It emits in-order results (redirect on mispredict, link writeback, sid) through a small output queue with backpressure toward writeback/commit.

---
 rtl/bru_pkg.sv | 42 ++++
 rtl/bru_out_fifo.sv | 66 ++++++
 rtl/branch_resolve_unit.sv | 194 +++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared constants, default result record and immediate decoders for the branch resolve unit.
// Immediate helpers return 32-bit sign-extended values; callers widen them to XLEN.
package bru_pkg;

  localparam logic [3:0] FC_JAL  = 4'b0111;
  localparam logic [3:0] FC_JALR = 4'b0101;
  localparam logic [3:0] FC_BR   = 4'b0100;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int unsigned BRU_XLEN  = 64;
  localparam int unsigned BRU_SID_W = 5;

  // Result record at the default widths; the top re-declares it at its own parameter widths.
  typedef struct packed {
    logic [BRU_SID_W-1:0] sid;
    logic                 redirect;
    logic [BRU_XLEN-1:0]  redirect_pc;
    logic                 wb_valid;
    logic [4:0]           rd;
    logic [BRU_XLEN-1:0]  wb_value;
    logic                 exc;
  } bru_result_t;

  function automatic logic [31:0] imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/bru_out_fifo.sv
// In-order result queue: synchronous FIFO of a result record with occupancy count.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module bru_out_fifo
  import bru_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = bru_result_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  T                       data_i,
  input  logic                   pop_i,
  output T                       head_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned  PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

  // NOTE: the storage is reset along with the pointers so the head register reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: E1 resolves jal/jalr/branch outcome against the prediction; results leave in order.
// Optional feature: define BRU_MISALIGN_EXC_EN to flag taken targets with target[1] set as exceptions.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned SID_W     = 5,
  parameter int unsigned OUT_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [XLEN-1:0]  in_pc_i,
  input  logic [31:0]      in_inst_i,
  input  logic [SID_W-1:0] in_sid_i,
  input  logic [XLEN-1:0]  rs1_value_i,
  input  logic [XLEN-1:0]  rs2_value_i,
  input  logic [3:0]       func_code_i,
  input  logic             pred_taken_i,
  input  logic [XLEN-1:0]  pred_pc_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [SID_W-1:0] out_sid_o,
  output logic             out_redirect_o,
  output logic [XLEN-1:0]  out_redirect_pc_o,
  output logic             out_wb_valid_o,
  output logic [4:0]       out_rd_o,
  output logic [XLEN-1:0]  out_wb_value_o,
  output logic             out_exc_o
);

  localparam int unsigned CNT_W = $clog2(OUT_DEPTH) + 1;

  typedef struct packed {
    logic [SID_W-1:0] sid;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;
    logic             wb_valid;
    logic [4:0]       rd;
    logic [XLEN-1:0]  wb_value;
    logic             exc;
  } result_t;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [31:0]      inst;
    logic [SID_W-1:0] sid;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [3:0]       fc;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_pc;
  } e1_op_t;

  e1_op_t           e1_q, e1_d;
  logic             e1_valid_q, e1_valid_d;
  logic             accept;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_valid;
  logic             fifo_pop;
  logic             fifo_push;
  result_t          e1_res;
  result_t          head;

  // Ready depends only on registered occupancy, so backpressure never forms a path from out_ready_i.
  assign in_ready_o = ({1'b0, fifo_count} + {{CNT_W{1'b0}}, e1_valid_q}) < (CNT_W + 1)'(OUT_DEPTH);
  assign accept     = in_valid_i && in_ready_o && !flush_i;

  // NOTE: every field gets a default before the conditional update so no latch is inferred.
  always_comb begin
    e1_valid_d = accept;
    e1_d       = e1_q;
    if (accept) begin
      e1_d.pc         = in_pc_i;
      e1_d.inst       = in_inst_i;
      e1_d.sid        = in_sid_i;
      e1_d.rs1        = rs1_value_i;
      e1_d.rs2        = rs2_value_i;
      e1_d.fc         = func_code_i;
      e1_d.pred_taken = pred_taken_i;
      e1_d.pred_pc    = pred_pc_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      e1_valid_q <= 1'b0;
      e1_q       <= '0;
    end else begin
      e1_valid_q <= e1_valid_d;
      e1_q       <= e1_d;
    end
  end

  logic            is_jal, is_jalr, is_br, is_jump, known_op;
  logic [2:0]      func3;
  logic [4:0]      rd;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target;
  logic            br_taken;
  logic            actual_taken;
  logic [XLEN-1:0] actual_pc;
  logic            unused_opcode;

  assign is_jal   = (e1_q.fc == FC_JAL);
  assign is_jalr  = (e1_q.fc == FC_JALR);
  assign is_br    = (e1_q.fc == FC_BR);
  assign is_jump  = is_jal || is_jalr;
  assign known_op = is_jump || is_br;
  assign func3    = e1_q.inst[14:12];
  assign rd       = e1_q.inst[11:7];
  assign pc_plus4 = e1_q.pc + XLEN'(4);

  // The opcode field is redundant with func_code, which issue has already decoded.
  assign unused_opcode = ^e1_q.inst[6:0];

  always_comb begin
    if (is_jal) begin
      target = e1_q.pc + XLEN'($signed(imm_j(e1_q.inst)));
    end else if (is_jalr) begin
      target = (e1_q.rs1 + XLEN'($signed(imm_i(e1_q.inst)))) & ~XLEN'(1);
    end else begin
      target = e1_q.pc + XLEN'($signed(imm_b(e1_q.inst)));
    end
  end

  always_comb begin
    case (func3)
      F3_BEQ:  br_taken = (e1_q.rs1 == e1_q.rs2);
      F3_BNE:  br_taken = (e1_q.rs1 != e1_q.rs2);
      F3_BLT:  br_taken = ($signed(e1_q.rs1) <  $signed(e1_q.rs2));
      F3_BGE:  br_taken = ($signed(e1_q.rs1) >= $signed(e1_q.rs2));
      F3_BLTU: br_taken = (e1_q.rs1 <  e1_q.rs2);
      F3_BGEU: br_taken = (e1_q.rs1 >= e1_q.rs2);
      default: br_taken = 1'b0;
    endcase
  end

  assign actual_taken = is_jump || (is_br && br_taken);
  assign actual_pc    = actual_taken ? target : pc_plus4;

  always_comb begin
    e1_res             = '0;
    e1_res.sid         = e1_q.sid;
    e1_res.redirect_pc = actual_pc;
    e1_res.rd          = rd;
    e1_res.wb_value    = pc_plus4;
    e1_res.redirect    = known_op &&
                         ((actual_taken != e1_q.pred_taken) ||
                          (actual_taken && (target != e1_q.pred_pc)));
    e1_res.wb_valid    = is_jump && (rd != 5'd0);
`ifdef BRU_MISALIGN_EXC_EN
    // A taken target off a 4-byte boundary traps instead of refetching or linking.
    if (actual_taken && target[1]) begin
      e1_res.exc      = 1'b1;
      e1_res.redirect = 1'b0;
      e1_res.wb_valid = 1'b0;
    end
`else
    e1_res.exc = 1'b0;
`endif
  end

  assign fifo_push = e1_valid_q && !flush_i;
  assign fifo_pop  = fifo_valid && out_ready_i;

  bru_out_fifo #(
    .DEPTH (OUT_DEPTH),
    .T     (result_t)
  ) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .push_i  (fifo_push),
    .data_i  (e1_res),
    .pop_i   (fifo_pop),
    .head_o  (head),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  assign out_valid_o       = fifo_valid;
  assign out_sid_o         = head.sid;
  assign out_redirect_o    = head.redirect;
  assign out_redirect_pc_o = head.redirect_pc;
  assign out_wb_valid_o    = head.wb_valid;
  assign out_rd_o          = head.rd;
  assign out_wb_value_o    = head.wb_value;
  assign out_exc_o         = head.exc;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: queue-based behavioural model compared every cycle,
// plus directed vectors with hand-computed expectations.
module tb_branch_resolve_unit;

  localparam int XLEN      = 64;
  localparam int SID_W     = 5;
  localparam int OUT_DEPTH = 2;

  localparam logic [3:0] JAL  = 4'b0111;
  localparam logic [3:0] JALR = 4'b0101;
  localparam logic [3:0] BR   = 4'b0100;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [XLEN-1:0]  in_pc_i;
  logic [31:0]      in_inst_i;
  logic [SID_W-1:0] in_sid_i;
  logic [XLEN-1:0]  rs1_value_i;
  logic [XLEN-1:0]  rs2_value_i;
  logic [3:0]       func_code_i;
  logic             pred_taken_i;
  logic [XLEN-1:0]  pred_pc_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [SID_W-1:0] out_sid_o;
  logic             out_redirect_o;
  logic [XLEN-1:0]  out_redirect_pc_o;
  logic             out_wb_valid_o;
  logic [4:0]       out_rd_o;
  logic [XLEN-1:0]  out_wb_value_o;
  logic             out_exc_o;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(XLEN), .SID_W(SID_W), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush_i           (flush_i),
    .in_valid_i        (in_valid_i),
    .in_ready_o        (in_ready_o),
    .in_pc_i           (in_pc_i),
    .in_inst_i         (in_inst_i),
    .in_sid_i          (in_sid_i),
    .rs1_value_i       (rs1_value_i),
    .rs2_value_i       (rs2_value_i),
    .func_code_i       (func_code_i),
    .pred_taken_i      (pred_taken_i),
    .pred_pc_i         (pred_pc_i),
    .out_valid_o       (out_valid_o),
    .out_ready_i       (out_ready_i),
    .out_sid_o         (out_sid_o),
    .out_redirect_o    (out_redirect_o),
    .out_redirect_pc_o (out_redirect_pc_o),
    .out_wb_valid_o    (out_wb_valid_o),
    .out_rd_o          (out_rd_o),
    .out_wb_value_o    (out_wb_value_o),
    .out_exc_o         (out_exc_o)
  );

  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [4:0]  sid;
    logic        redirect;
    logic [63:0] rpc;
    logic        wbv;
    logic [4:0]  rd;
    logic [63:0] wbval;
    logic        exc;
    longint      vis;
  } exp_t;

  exp_t       model_q[$];
  logic [4:0] pop_log[$];

  function automatic exp_t predict(input logic [4:0] sid, input logic [63:0] pc, input logic [31:0] inst,
                                   input logic [63:0] a, input logic [63:0] b, input logic [3:0] fc,
                                   input logic pt, input logic [63:0] ppc, input longint vis);
    exp_t        r;
    longint      imm;
    logic [63:0] tgt;
    bit          taken;
    bit          known;
    imm   = 0;
    tgt   = 0;
    taken = 0;
    known = 1;
    if (fc == JAL) begin
      imm = longint'({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
      if (inst[31]) imm -= (longint'(1) << 21);
      tgt   = pc + 64'(imm);
      taken = 1;
    end else if (fc == JALR) begin
      imm = longint'(inst[31:20]);
      if (inst[31]) imm -= 4096;
      tgt   = (a + 64'(imm)) & ~64'd1;
      taken = 1;
    end else if (fc == BR) begin
      imm = longint'({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
      if (inst[31]) imm -= 8192;
      tgt = pc + 64'(imm);
      case (inst[14:12])
        3'd0: taken = (a == b);
        3'd1: taken = (a != b);
        3'd4: taken = ($signed(a) < $signed(b));
        3'd5: taken = ($signed(a) >= $signed(b));
        3'd6: taken = (a < b);
        3'd7: taken = (a >= b);
        default: taken = 0;
      endcase
    end else begin
      known = 0;
    end
    r.sid      = sid;
    r.rpc      = taken ? tgt : pc + 64'd4;
    r.redirect = known && ((taken != pt) || (taken && tgt != ppc));
    r.wbv      = (fc == JAL || fc == JALR) && (inst[11:7] != 5'd0);
    r.rd       = inst[11:7];
    r.wbval    = pc + 64'd4;
    r.exc      = 0;
`ifdef BRU_MISALIGN_EXC_EN
    if (known && taken && tgt[1]) begin
      r.exc      = 1;
      r.redirect = 0;
      r.wbv      = 0;
    end
`endif
    r.vis = vis;
    return r;
  endfunction

  // Model advances at each active edge, compares on the following falling edge.
  initial begin
    bit   acc;
    bit   pop;
    bit   mv;
    exp_t h;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        model_q.delete();
      end else begin
        mv  = (model_q.size() > 0) && (model_q[0].vis <= cyc - 1);
        acc = in_valid_i && (model_q.size() < OUT_DEPTH) && !flush_i;
        pop = mv && out_ready_i && !flush_i;
        if (flush_i) begin
          model_q.delete();
        end else begin
          if (pop) void'(model_q.pop_front());
          if (acc) model_q.push_back(predict(in_sid_i, in_pc_i, in_inst_i, rs1_value_i, rs2_value_i,
                                             func_code_i, pred_taken_i, pred_pc_i, cyc + 1));
        end
      end
      @(negedge clk);
      if (!rst) begin
        mv = (model_q.size() > 0) && (model_q[0].vis <= cyc);
        check("in_ready", in_ready_o, model_q.size() < OUT_DEPTH);
        check("out_valid", out_valid_o, mv);
        if (mv && out_valid_o) begin
          h = model_q[0];
          check("sid", out_sid_o, h.sid);
          check("redirect", out_redirect_o, h.redirect);
          check("redirect_pc", out_redirect_pc_o, h.rpc);
          check("wb_valid", out_wb_valid_o, h.wbv);
          check("rd", out_rd_o, h.rd);
          check("wb_value", out_wb_value_o, h.wbval);
          check("exc", out_exc_o, h.exc);
        end
        if (out_valid_o && out_ready_i && !flush_i) pop_log.push_back(out_sid_o);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] enc_b(input int imm, input logic [2:0] f3);
    logic [12:0] v = imm[12:0];
    return {v[12], v[10:5], 5'd2, 5'd1, f3, v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input logic [4:0] rd);
    logic [20:0] v = imm[20:0];
    return {v[20], v[10:1], v[11], v[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rd);
    logic [11:0] v = imm[11:0];
    return {v, 5'd1, 3'b000, rd, 7'b1100111};
  endfunction

  task automatic issue(input logic [4:0] sid, input logic [63:0] pc, input logic [31:0] inst,
                       input logic [63:0] a, input logic [63:0] b, input logic [3:0] fc,
                       input logic pt, input logic [63:0] ppc);
    bit r = 0;
    in_valid_i   = 1'b1;
    in_sid_i     = sid;
    in_pc_i      = pc;
    in_inst_i    = inst;
    rs1_value_i  = a;
    rs2_value_i  = b;
    func_code_i  = fc;
    pred_taken_i = pt;
    pred_pc_i    = ppc;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      r = in_ready_o;
      @(posedge clk);
      #1;
      if (r) break;
    end
    if (!r) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: sid %0d not accepted within 50 cycles", sid);
    end
  endtask

  task automatic idle();
    in_valid_i = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [4:0] sid, input logic redir,
                            input logic [63:0] rpc, input logic wbv, input logic [4:0] rd,
                            input logic [63:0] wbval, input logic exc);
    bit seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid_o && out_sid_o == sid) begin
        seen = 1;
        break;
      end
    end
    check({name, "_seen"}, seen, 1'b1);
    if (seen) begin
      check({name, "_redirect"}, out_redirect_o, redir);
      check({name, "_rpc"}, out_redirect_pc_o, rpc);
      check({name, "_wbv"}, out_wb_valid_o, wbv);
      check({name, "_rd"}, out_rd_o, rd);
      check({name, "_wbval"}, out_wb_value_o, wbval);
      check({name, "_exc"}, out_exc_o, exc);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    in_pc_i = '0; in_inst_i = '0; in_sid_i = '0; rs1_value_i = '0; rs2_value_i = '0;
    func_code_i = '0; pred_taken_i = 1'b0; pred_pc_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_in_ready", in_ready_o, 1'b1);
    check("rst_redirect", out_redirect_o, 1'b0);
    check("rst_redirect_pc", out_redirect_pc_o, 64'd0);
    check("rst_wb_valid", out_wb_valid_o, 1'b0);
    check("rst_wb_value", out_wb_value_o, 64'd0);
    check("rst_sid", out_sid_o, 5'd0);
    check("rst_exc", out_exc_o, 1'b0);
    @(posedge clk);
    #1;

    // beq taken, predicted not taken
    issue(5'd1, 64'h1000, enc_b(16, 3'b000), 64'd5, 64'd5, BR, 1'b0, 64'h0);
    idle();
    expect_out("beq", 5'd1, 1'b1, 64'h1010, 1'b0, 5'd16, 64'h1004, 1'b0);

    // blt taken, predicted correctly
    issue(5'd2, 64'h2000, enc_b(-8, 3'b100), 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, BR, 1'b1, 64'h1FF8);
    idle();
    expect_out("blt", 5'd2, 1'b0, 64'h1FF8, 1'b0, 5'd25, 64'h2004, 1'b0);

    // bltu same operands: not taken, predicted not taken
    issue(5'd3, 64'h2000, enc_b(-8, 3'b110), 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, BR, 1'b0, 64'h0);
    idle();
    expect_out("bltu", 5'd3, 1'b0, 64'h2004, 1'b0, 5'd25, 64'h2004, 1'b0);

    // jalr: target bit 0 cleared, link to x1
    issue(5'd4, 64'h3000, enc_i(4, 5'd1), 64'h2001, 64'd0, JALR, 1'b1, 64'h2004);
    idle();
    expect_out("jalr", 5'd4, 1'b0, 64'h2004, 1'b1, 5'd1, 64'h3004, 1'b0);

    // jal to a half-word aligned target
    issue(5'd5, 64'h1000, enc_j(2, 5'd0), 64'd0, 64'd0, JAL, 1'b0, 64'h0);
    idle();
`ifdef BRU_MISALIGN_EXC_EN
    expect_out("jal_mis", 5'd5, 1'b0, 64'h1002, 1'b0, 5'd0, 64'h1004, 1'b1);
`else
    expect_out("jal_mis", 5'd5, 1'b1, 64'h1002, 1'b0, 5'd0, 64'h1004, 1'b0);
`endif

    // unknown func_code never redirects or writes back
    issue(5'd6, 64'h4000, enc_j(8, 5'd3), 64'd0, 64'd0, 4'b0000, 1'b1, 64'h4008);
    idle();
    expect_out("unknown", 5'd6, 1'b0, 64'h4004, 1'b0, 5'd3, 64'h4004, 1'b0);

    // reserved func3 010: not taken although predicted taken
    issue(5'd7, 64'h5000, enc_b(16, 3'b010), 64'd1, 64'd1, BR, 1'b1, 64'h5010);
    idle();
    expect_out("f3_010", 5'd7, 1'b1, 64'h5004, 1'b0, 5'd16, 64'h5004, 1'b0);

    // jal backward with link, predicted correctly
    issue(5'd8, 64'h6000, enc_j(-256, 5'd5), 64'd0, 64'd0, JAL, 1'b1, 64'h5F00);
    idle();
    expect_out("jal_back", 5'd8, 1'b0, 64'h5F00, 1'b1, 5'd5, 64'h6004, 1'b0);

    // jal predicted taken to the wrong target
    issue(5'd9, 64'h7000, enc_j(64, 5'd2), 64'd0, 64'd0, JAL, 1'b1, 64'h7080);
    idle();
    expect_out("jal_wrongpc", 5'd9, 1'b1, 64'h7040, 1'b1, 5'd2, 64'h7004, 1'b0);

    // back-to-back burst with toggling out_ready; the model checks every result
    fork
      begin
        issue(5'd13, 64'h100, enc_b(-4, 3'b001), 64'd3, 64'd3, BR, 1'b1, 64'hFC);
        issue(5'd14, 64'h104, enc_b(8, 3'b101), -64'sd5, -64'sd5, BR, 1'b0, 64'h0);
        issue(5'd15, 64'h108, enc_b(12, 3'b111), 64'd1, 64'hFFFF_FFFF_FFFF_0000, BR, 1'b0, 64'h0);
        issue(5'd16, 64'h10C, enc_b(20, 3'b100), 64'd5, -64'sd3, BR, 1'b1, 64'h120);
        issue(5'd17, 64'h110, enc_b(-16, 3'b110), 64'd2, 64'd9, BR, 1'b1, 64'h100);
        issue(5'd18, 64'h114, enc_i(-3, 5'd7), 64'h8000, 64'd0, JALR, 1'b1, 64'h7FFC);
        issue(5'd19, 64'hFFFF_FFFF_FFFF_FFF0, enc_b(32, 3'b000), 64'd0, 64'd0, BR, 1'b1, 64'h10);
        issue(5'd20, 64'h200, enc_b(4094, 3'b000), 64'd0, 64'd0, BR, 1'b1, 64'h11FE);
        idle();
      end
      begin
        repeat (12) begin
          @(posedge clk);
          #1 out_ready_i = ~out_ready_i;
        end
        out_ready_i = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;

    // backpressure: three ops with out_ready low, ready drops after two
    out_ready_i = 1'b0;
    pop_log.delete();
    issue(5'd10, 64'h800, enc_b(8, 3'b000), 64'd1, 64'd2, BR, 1'b0, 64'h0);
    issue(5'd11, 64'h804, enc_j(16, 5'd4), 64'd0, 64'd0, JAL, 1'b1, 64'h814);
    in_sid_i = 5'd12;
    @(negedge clk);
    check("bp_ready_low", in_ready_o, 1'b0);
    fork
      issue(5'd12, 64'h808, enc_i(0, 5'd6), 64'h900, 64'd0, JALR, 1'b0, 64'h0);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready_i = 1'b1;
      end
    join
    idle();
    repeat (6) @(posedge clk);
    #1;
    check("bp_count", pop_log.size(), 3);
    if (pop_log.size() == 3) begin
      check("bp_order0", pop_log[0], 5'd10);
      check("bp_order1", pop_log[1], 5'd11);
      check("bp_order2", pop_log[2], 5'd12);
    end

    // flush with E1 valid and a queued result: nothing may come out
    out_ready_i = 1'b0;
    pop_log.delete();
    issue(5'd21, 64'hA00, enc_b(8, 3'b000), 64'd0, 64'd0, BR, 1'b0, 64'h0);
    issue(5'd22, 64'hA04, enc_j(8, 5'd1), 64'd0, 64'd0, JAL, 1'b0, 64'h0);
    idle();
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid_o, 1'b0);
    check("flush_in_ready", in_ready_o, 1'b1);
    check("flush_redirect", out_redirect_o && out_valid_o, 1'b0);
    out_ready_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("flush_no_output", pop_log.size(), 0);

    // after a flush the unit resumes normally
    issue(5'd23, 64'hB00, enc_b(-32, 3'b001), 64'd7, 64'd8, BR, 1'b1, 64'hAE0);
    idle();
    expect_out("post_flush", 5'd23, 1'b0, 64'hAE0, 1'b0, 5'd1, 64'hB04, 1'b0);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
